mode_select_ctrl: RTL
=====================

Name: mode_select_ctrl

Overview:
- Front end of the AC/DC mode path: takes the two raw, asynchronous, active-low front-panel buttons (ac_button, dc_button).
- Synchronises and debounces both buttons, detects press edges, and holds the registered measurement mode.
- Feeds the downstream mode consumer (measurement/VGA display stage) a clean mode code plus one-cycle change/press strobes.

Parameters:
- DEBOUNCE_CYCLES, 100: consecutive synced samples that must disagree with the stable level before the stable level flips (min 2).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; do not override.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- ac_button  in  1  raw AC button, active-low (0 = pressed), asynchronous to clk.
- dc_button  in  1  raw DC button, active-low, asynchronous to clk.
- mode  out  2  registered mode: 2'b00 NONE, 2'b01 AC, 2'b10 DC; 2'b11 never driven.
- mode_valid  out  1  high when mode != NONE.
- mode_changed  out  1  one-cycle pulse in the cycle mode takes a new value.
- ac_pressed  out  1  one-cycle pulse on debounced AC press (stable 1->0).
- dc_pressed  out  1  one-cycle pulse on debounced DC press.

Behaviour:
- Reset (async assert, sync release): sync flops = 1, stable levels = 1 (released), counters = 0, mode = NONE. mode_valid, mode_changed, ac_pressed, dc_pressed all 0.
- Sync: each button passes through a 2-FF synchroniser; only the second flop output (btn_s) is used.
- Debounce, per button:
  - btn_s == stable: counter cleared to 0.
  - btn_s != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - btn_s != stable and counter == DEBOUNCE_CYCLES-1: stable <= btn_s, counter <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES synced cycles is rejected, because the counter restarts from 0.
  - Counter saturates by construction and never wraps.
- Press pulse: xx_pressed = 1 for exactly the one cycle after stable goes 1->0. Release (0->1) produces no pulse.
- Latency: a clean input change sampled at edge k gives stable updated at edge k+1+DEBOUNCE_CYCLES and xx_pressed high for the following cycle.
- Mode FSM (states NONE, AC, DC), evaluated on the press pulses:
  - ac_pressed only: next = AC.
  - dc_pressed only: next = DC.
  - Both in the same cycle: state unchanged, no mode_changed; both pulses still output.
  - Press of the already-active mode: no change, no mode_changed.
  - mode registers one cycle after the press pulse. mode_changed is high in that same cycle.
  - No path returns to NONE except reset (see optional feature).
- Holding a button: exactly one press pulse. Another requires a debounced release and then a debounced press.
- Reset mid-debounce: counters and stable levels return to reset values immediately. A button still held low after release of rst_n is re-debounced and generates a press.

Optional Feature:
- Macro: MODE_SELECT_TOGGLE_EN.
- Defined: a press of the active mode's button returns mode to NONE with a mode_changed pulse. AC->(ac press)->NONE; DC->(dc press)->NONE.
- Not defined: a same-mode press is ignored, as specified above.
- Simultaneous-press rule is identical in both builds.

Decomposition:
- Package mode_select_pkg holds:
  - mode_t encoding constants MODE_NONE=2'b00, MODE_AC=2'b01, MODE_DC=2'b10.
  - MODE_W=2.
  - This package is shared with the downstream display/measurement consumer.
- Sub-module button_debounce (params DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw_n, stable, pressed):
  - Contains the synchroniser, counter, and edge detect.
  - Instantiated twice; the mode FSM lives in the top.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset then idle with both buttons high for 20 cycles -> mode=00, mode_valid=0, all pulses 0 throughout.
2. ac_button driven low and held -> ac_pressed high exactly 1 cycle, 6 cycles after the sampling edge. Next cycle mode=01, mode_changed=1 for 1 cycle. No further pulses while held.
3. dc_button low-pulsed for 3 cycles, then high -> no dc_pressed, mode unchanged. Then held low for 10 cycles -> dc_pressed once, mode 01->10, one mode_changed.
4. Both buttons released, then driven low on the same edge -> ac_pressed and dc_pressed in the same cycle; mode stays 10, mode_changed stays 0.
5. mode=AC, AC pressed again -> without MODE_SELECT_TOGGLE_EN: mode stays 01, no mode_changed. With it: mode=00, mode_changed pulses, mode_valid=0.
6. rst_n asserted while ac_button held low mid-count (counter=2) -> outputs zero immediately. After release with the button still low -> fresh 4-cycle debounce, ac_pressed once, mode=01.

Source files
------------

// File: rtl/mode_select_pkg.sv
// Mode encoding shared by the AC/DC mode front end and the downstream
// measurement/display consumer.
package mode_select_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_NONE = 2'b00,
    MODE_AC   = 2'b01,
    MODE_DC   = 2'b10
  } mode_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, counter-based debouncer and press (1->0) edge
// detector for one active-low push button.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_n,
  output logic stable,
  output logic pressed
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  logic             stable_q, stable_d;
  logic             stable_prev_q;
  logic             pressed_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign btn_s = sync_q[1];

  // Any sample matching the stable level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES disagreeing samples flips the level.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (btn_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = btn_s;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '1;
      stable_q      <= 1'b1;
      stable_prev_q <= 1'b1;
      cnt_q         <= '0;
      pressed_q     <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], btn_raw_n};
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      pressed_q     <= stable_prev_q & ~stable_q;
    end
  end

  assign stable  = stable_q;
  assign pressed = pressed_q;

endmodule

// File: rtl/mode_select_ctrl.sv
// AC/DC mode front end: debounces both buttons and holds the registered mode.
// Optional build macro MODE_SELECT_TOGGLE_EN: same-mode press returns to NONE.
module mode_select_ctrl
  import mode_select_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ac_button,
  input  logic              dc_button,
  output logic [MODE_W-1:0] mode,
  output logic              mode_valid,
  output logic              mode_changed,
  output logic              ac_pressed,
  output logic              dc_pressed
);

  logic  ac_stable, dc_stable;
  logic  unused_stable;
  mode_t mode_q, mode_d;
  logic  mode_valid_q, mode_changed_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ac_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw_n (ac_button),
    .stable    (ac_stable),
    .pressed   (ac_pressed)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dc_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw_n (dc_button),
    .stable    (dc_stable),
    .pressed   (dc_pressed)
  );

  assign unused_stable = ac_stable ^ dc_stable;

  // Simultaneous presses are ambiguous and leave the mode untouched.
  always_comb begin
    mode_d = mode_q;
    if (ac_pressed && !dc_pressed) begin
      if (mode_q != MODE_AC) mode_d = MODE_AC;
`ifdef MODE_SELECT_TOGGLE_EN
      else                   mode_d = MODE_NONE;
`endif
    end else if (dc_pressed && !ac_pressed) begin
      if (mode_q != MODE_DC) mode_d = MODE_DC;
`ifdef MODE_SELECT_TOGGLE_EN
      else                   mode_d = MODE_NONE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q         <= MODE_NONE;
      mode_valid_q   <= 1'b0;
      mode_changed_q <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      mode_valid_q   <= (mode_d != MODE_NONE);
      mode_changed_q <= (mode_d != mode_q);
    end
  end

  assign mode         = mode_q;
  assign mode_valid   = mode_valid_q;
  assign mode_changed = mode_changed_q;

endmodule
